// File: rtl/t_chain_pkg.sv
// Shared types and helpers for the T-cell chain counter.
package t_chain_pkg;

   // Count direction as carried on up_dn
   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } dir_e;

   localparam int unsigned MIN_WIDTH   = 1;
   localparam int unsigned MAX_WIDTH   = 16;
   localparam int unsigned MIN_MODULUS = 2;

   // Saturate a requested load value into the legal count range 0..modulus-1
   function automatic int unsigned clamp_load(input int unsigned value,
                                              input int unsigned modulus);
      return (value >= modulus) ? (modulus - 1) : value;
   endfunction

endpackage

// File: rtl/t_chain_counter_t_cell.sv
// Single-bit T flip-flop: toggles on t, holds otherwise, async active-low clear.
module t_cell (
   input  logic clk,
   input  logic rst,
   input  logic t,
   output logic q
);

   // Toggle register; reset forces the bit low without a clock
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q <= 1'b0;
      end else if (t) begin
         q <= ~q;
      end
   end

endmodule

// File: rtl/t_chain_counter.sv
// Modulo up/down counter built from a chain of T cells.
// Next value is chosen (load > up > down > hold), turned into a toggle mask
// q ^ next, and every cell flips on the same edge, so q never ripples.
// tc is the combinational carry/borrow used to cascade further stages.
// Optional build macro T_CHAIN_OVF_STICKY_EN adds clr_ovf/ovf, a sticky
// record that a wrap has happened since the last clear.
module t_chain_counter
   import t_chain_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
`ifdef T_CHAIN_OVF_STICKY_EN
   input  logic             clr_ovf,
   output logic             ovf,
`endif
   output logic [WIDTH-1:0] q,
   output logic             tc
);

   // Reject illegal configurations while elaborating
   if (WIDTH < int'(MIN_WIDTH) || WIDTH > int'(MAX_WIDTH)) begin : g_bad_width
      $fatal(1, "t_chain_counter: WIDTH=%0d outside 1..16", WIDTH);
   end
   if (MODULUS < int'(MIN_MODULUS) || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
      $fatal(1, "t_chain_counter: MODULUS=%0d outside 2..2**WIDTH", MODULUS);
   end

   // Highest count; for a full binary range this is all ones
   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

   dir_e             dir;
   logic             at_top;
   logic             at_bottom;
   logic [WIDTH-1:0] load_clamped;
   logic [WIDTH-1:0] nxt;
   logic [WIDTH-1:0] tmask;

   assign dir       = dir_e'(up_dn);
   // >= also covers a forced out-of-range q, which wraps straight to 0 going up
   assign at_top    = (q >= MAX_VAL);
   assign at_bottom = (q == '0);

   assign load_clamped = WIDTH'(clamp_load(32'(load_val), 32'(MODULUS)));

   // Next-value selection: load beats counting, counting beats hold
   always_comb begin
      nxt = q;
      if (load) begin
         nxt = load_clamped;
      end else if (en && (dir == DIR_UP)) begin
         nxt = at_top ? '0 : (q + WIDTH'(1));
      end else if (en && (dir == DIR_DOWN)) begin
         nxt = at_bottom ? MAX_VAL : (q - WIDTH'(1));
      end
   end

   // Each cell only needs to know whether its bit differs from the target
   assign tmask = q ^ nxt;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      t_cell u_cell (
         .clk (clk),
         .rst (rst),
         .t   (tmask[i]),
         .q   (q[i])
      );
   end

   // Carry/borrow for the edge that wraps; forced low while held in reset
   assign tc = rst && en && !load &&
               (((dir == DIR_UP) && (q == MAX_VAL)) ||
                ((dir == DIR_DOWN) && at_bottom));

`ifdef T_CHAIN_OVF_STICKY_EN
   // Sticky wrap flag; a wrap on the same edge as a clear keeps it set
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ovf <= 1'b0;
      end else if (tc) begin
         ovf <= 1'b1;
      end else if (clr_ovf) begin
         ovf <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_t_chain_counter.sv
// Scoreboard bench for t_chain_counter: two instances (MODULUS 10 and the
// full 4-bit range 16) receive identical stimulus; a reference model in
// integer arithmetic predicts tc and the next q, and a monitor compares.
module tb_t_chain_counter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       up_dn = 1'b0;
   logic       load = 1'b0;
   logic       clr_ovf = 1'b0;
   logic [3:0] load_val = 4'd0;
   logic [3:0] q10, q16;
   logic       tc10, tc16;
`ifdef T_CHAIN_OVF_STICKY_EN
   logic       ovf10, ovf16;
`endif

   int tests = 0;
   int fails = 0;

   typedef struct {
      int tc10;
      int tc16;
      int q10;
      int q16;
      int ovf10;
      int ovf16;
   } exp_t;

   exp_t sbq[$];

   int m10 = 0, m16 = 0, mo10 = 0, mo16 = 0;

   always #5 clk = ~clk;

   t_chain_counter #(.WIDTH(4), .MODULUS(10)) dut10 (
      .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
      .load_val(load_val),
`ifdef T_CHAIN_OVF_STICKY_EN
      .clr_ovf(clr_ovf), .ovf(ovf10),
`endif
      .q(q10), .tc(tc10));

   t_chain_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
      .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
      .load_val(load_val),
`ifdef T_CHAIN_OVF_STICKY_EN
      .clr_ovf(clr_ovf), .ovf(ovf16),
`endif
      .q(q16), .tc(tc16));

   function automatic int model_next(int q, int m, bit l, bit e, bit u, int lv);
      if (l) return (lv >= m) ? m - 1 : lv;
      if (!e) return q;
      if (u) return (q + 1) % m;
      return (q + m - 1) % m;
   endfunction

   function automatic int model_tc(int q, int m, bit l, bit e, bit u);
      if (l || !e) return 0;
      if (u) return (q == m - 1) ? 1 : 0;
      return (q == 0) ? 1 : 0;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // One stimulus cycle: drive inputs, predict the response, queue it
   task automatic step(input bit l, input bit e, input bit u, input bit c, input int lv);
      exp_t x;
      @(posedge clk);
      #2;
      load = l; en = e; up_dn = u; clr_ovf = c; load_val = 4'(lv);
      x.tc10 = model_tc(m10, 10, l, e, u);
      x.tc16 = model_tc(m16, 16, l, e, u);
      m10 = model_next(m10, 10, l, e, u, lv);
      m16 = model_next(m16, 16, l, e, u, lv);
      if (x.tc10 != 0) mo10 = 1; else if (c) mo10 = 0;
      if (x.tc16 != 0) mo16 = 1; else if (c) mo16 = 0;
      x.q10 = m10; x.q16 = m16; x.ovf10 = mo10; x.ovf16 = mo16;
      sbq.push_back(x);
   endtask

   // Park inputs at hold and let the monitor finish the last item
   task automatic quiesce();
      step(0, 0, 0, 0, 0);
      @(posedge clk);
      #3;
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_q10"}, 32'(q10), 0);
      chk({tag, "_q16"}, 32'(q16), 0);
      chk({tag, "_tc10"}, 32'(tc10), 0);
      chk({tag, "_tc16"}, 32'(tc16), 0);
`ifdef T_CHAIN_OVF_STICKY_EN
      chk({tag, "_ovf10"}, 32'(ovf10), 0);
      chk({tag, "_ovf16"}, 32'(ovf16), 0);
`endif
   endtask

   // Monitor: tc mid-cycle while inputs are stable, q just after the edge
   initial begin
      exp_t x;
      forever begin
         @(negedge clk);
         if (sbq.size() != 0) begin
            x = sbq.pop_front();
            chk("tc10", 32'(tc10), x.tc10);
            chk("tc16", 32'(tc16), x.tc16);
            @(posedge clk);
            #1;
            chk("q10", 32'(q10), x.q10);
            chk("q16", 32'(q16), x.q16);
`ifdef T_CHAIN_OVF_STICKY_EN
            chk("ovf10", 32'(ovf10), x.ovf10);
            chk("ovf16", 32'(ovf16), x.ovf16);
`endif
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Power-on reset with no edge; en/down would otherwise raise tc
      #1 rst = 1'b0; en = 1'b1; up_dn = 1'b0;
      #1 check_reset_state("por");
      en = 1'b0;
      #6 rst = 1'b1;

      // Count to 7, then clear asynchronously between edges
      repeat (7) step(0, 1, 1, 0, 0);
      quiesce();
      chk("pre_rst_q10", 32'(q10), 7);
      en = 1'b1; up_dn = 1'b0;
      rst = 1'b0;
      #1 check_reset_state("mid");
      en = 1'b0;
      #1 rst = 1'b1;
      m10 = 0; m16 = 0; mo10 = 0; mo16 = 0;
      repeat (3) step(0, 1, 1, 0, 0);

      // Up through the wrap of both moduli (9->0 and 15->0)
      repeat (14) step(0, 1, 1, 0, 0);
      step(0, 0, 1, 1, 0);

      // Down wrap from 0
      step(1, 0, 0, 0, 0);
      repeat (3) step(0, 1, 0, 0, 0);

      // Load wins over en, then clamp
      step(1, 1, 1, 0, 5);
      step(1, 1, 0, 0, 12);
      step(1, 1, 1, 0, 15);

      // Hold at 4 for five cycles
      step(1, 0, 0, 0, 4);
      repeat (5) step(0, 0, 1, 0, 0);

      // Direction flip at 3
      step(1, 0, 0, 0, 0);
      repeat (3) step(0, 1, 1, 0, 0);
      repeat (2) step(0, 1, 0, 0, 0);

      // Full-range wrap, then clear the sticky flag
      step(1, 0, 0, 1, 15);
      step(0, 1, 1, 0, 0);
      step(0, 0, 1, 0, 0);
      step(0, 0, 1, 1, 0);

      // Randomized traffic
      repeat (400) begin
         step($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0,
              int'($urandom_range(0, 15)));
      end

      quiesce();
      for (int i = 0; i < 10 && sbq.size() != 0; i++) @(posedge clk);
      tests++;
      if (sbq.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d items pending, expected 0", sbq.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/t_chain_counter.md
Name: t_chain_counter

Overview:
- Synchronous modulo up/down counter built from a chain of T flip-flop cells.
- Consumes the T-FF primitive: a toggle-mask generator drives one T cell per bit.
- Produces a count value and a terminal-count strobe for cascading.
- Used as the divider/timebase stage directly downstream of the T flip-flop primitive.

Parameters:
- WIDTH, 4, counter width in bits (1..16).
- MODULUS, 10, count range 0..MODULUS-1. Legal range is 2 <= MODULUS <= 2**WIDTH; anything outside is a fatal elaboration error.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- en  input  1  count enable
- up_dn  input  1  1 = count up, 0 = count down
- load  input  1  synchronous load strobe
- load_val  input  WIDTH  value to load
- q  output  WIDTH  current count (registered, straight from the T cells)
- tc  output  1  terminal count / carry-out (combinational)

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous and active-low.
  - rst low: q = 0 immediately, with no clock required.
  - rst release: takes effect at the next rising edge of clk after rst goes high.
- Next-value selection, priority per rising edge, highest first:
  - load: next = load_val, or MODULUS-1 if load_val >= MODULUS (clamp).
  - else en && up_dn: next = (q == MODULUS-1) ? 0 : q+1.
  - else en && !up_dn: next = (q == 0) ? MODULUS-1 : q-1.
  - else: next = q (hold).
- Toggle mode:
  - Toggle mask T = q ^ next, one bit per cell.
  - A cell toggles its bit when T[i] = 1 and holds when T[i] = 0.
  - All bits update on the same edge, so there are no ripple glitches on q.
- Latency: one cycle from a load/en sample to the new q.
- Terminal count:
  - tc = en && !load && ((up_dn && q == MODULUS-1) || (!up_dn && q == 0)).
  - tc is asserted during the cycle whose edge produces the wrap.
  - tc is 0 during reset.
- Direction change: up_dn may change on any cycle and takes effect on the next edge. There is no extra state.
- Out-of-range q: unreachable by construction. If a forced q >= MODULUS occurs, counting up wraps to 0 and counting down goes to q-1.
- Reset mid-operation: asynchronous clear wins over load and en on the same edge.
- Width rules:
  - All compares are unsigned, WIDTH bits.
  - MODULUS-1 is truncated to WIDTH bits.
  - MODULUS == 2**WIDTH gives natural binary wrap.

Optional Feature:
- Macro: T_CHAIN_OVF_STICKY_EN.
- With the macro defined:
  - Adds input clr_ovf (1 bit) and output ovf (1 bit).
  - ovf is a sticky flag, set on the edge where tc = 1.
  - clr_ovf clears ovf synchronously.
  - Set wins over clear on the same edge.
  - Reset value of ovf is 0.
- Without the macro: neither port exists and no flag register is built.

Decomposition:
- Package t_chain_pkg holds:
  - function clamp_load(value, modulus).
  - localparam typedef of the direction encoding (DIR_DOWN = 0, DIR_UP = 1).
- Sub-module t_cell:
  - Single-bit T flip-flop with async active-low reset.
  - Ports clk, rst, t, q.
  - Instantiated WIDTH times by a generate loop.
- Top level contains only next-value logic, toggle mask, tc, and the optional ovf flag.

Test Plan:
- Reset: drive rst low mid-count at q = 7 without a clock edge -> q = 0 immediately; after release with en = 1, up_dn = 1, q counts 1, 2, 3 on successive edges.
- Up wrap (MODULUS = 10): count from 0 with en = 1 -> q reaches 9, tc = 1 for exactly that cycle, next edge q = 0, tc = 0.
- Down wrap: load 0, then en = 1, up_dn = 0 -> tc = 1 while q = 0; next edge q = 9, then 8.
- Load priority and clamp:
  - load = 1, en = 1, load_val = 5 -> q = 5 and tc = 0 that cycle.
  - load_val = 12 -> q = 9.
- Hold: en = 0 for 5 cycles at q = 4 -> q stays 4 and tc stays 0.
- Full-range and direction flip: WIDTH = 4, MODULUS = 16, q = 15 up -> 0 with tc = 1; flip up_dn at q = 3 -> q goes 2 on the next edge. With T_CHAIN_OVF_STICKY_EN, ovf = 1 after the wrap and clears on clr_ovf.
